// File: rtl/ddr_axi_arb_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : ddr_axi_arb_pkg
// Purpose  : Shared types and constants for the three-way DDR AXI arbiter:
//            master index encoding, address FSM states, AXI field widths and
//            the round-robin successor helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package ddr_axi_arb_pkg;

   localparam int IDX_W   = 2;
   localparam int N_MST   = 3;
   localparam int LEN_W   = 4;
   localparam int SIZE_W  = 3;
   localparam int BURST_W = 2;

   typedef enum logic [IDX_W-1:0] {
      M_AUDIO = 2'd0,
      M_DEMUX = 2'd1,
      M_GDMA  = 2'd2
   } master_e;

   typedef enum logic [0:0] {
      A_IDLE = 1'b0,
      A_BUSY = 1'b1
   } astate_e;

   // Round-robin successor: audio -> demux -> gdma -> audio
   function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx);
      return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ddr_axi_arb_wq.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : ddr_axi_arb_wq
// Purpose  : Write grant-order queue. Holds the master index of every granted
//            write so the write data channel follows address grant order.
// Ports    : i_clk, i_rst_n          clock, async active-low reset
//            i_push, i_push_idx      enqueue a master index
//            i_pop                   dequeue the head
//            o_head                  head index (0 while empty)
//            o_full, o_empty         occupancy flags
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module ddr_axi_arb_wq
   import ddr_axi_arb_pkg::*;
#(
   parameter int WQ_DEPTH = 4
)(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic [IDX_W-1:0] i_push_idx,
   input  logic             i_pop,
   output logic [IDX_W-1:0] o_head,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = (WQ_DEPTH > 1) ? $clog2(WQ_DEPTH) : 1;

   logic [IDX_W-1:0] r_mem [WQ_DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_push_ok;
   logic             w_pop_ok;

   // Extra pointer bit distinguishes full from empty
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

   // A push while full is legal only when the head leaves in the same cycle
   assign w_push_ok = i_push & (~o_full | i_pop);
   assign w_pop_ok  = i_pop & ~o_empty;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         for (int i = 0; i < WQ_DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_push_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_push_idx;
            r_wr_ptr                <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
         end
         if (w_pop_ok) r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
      end
   end

endmodule
`default_nettype wire

// File: rtl/ddr_axi_arb.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : ddr_axi_arb
// Purpose  : Shares one DDR AXI master port between audio (read), demux
//            (write) and gdma (read/write). Round-robin address arbitration,
//            write data ordered by grant queue, read data routed by ID tag.
// Ports    : gclk, gresetn                   clock, async active-low reset
//            a*_<m> / aready_<m>             requester address channels
//            w*_<m> / wready_<m>             demux/gdma write data
//            r*_<m> / rready_<m>             audio/gdma read return
//            a*_ddr, w*_ddr, r*_ddr          DDR controller port (ID+2 bits)
//            rsp_err                         sticky unroutable read ID flag
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module ddr_axi_arb
   import ddr_axi_arb_pkg::*;
#(
   parameter int ID_W     = 4,
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 64,
   parameter int WQ_DEPTH = 4
)(
   input  logic                  gclk,
   input  logic                  gresetn,
   // audio address
   input  logic [ID_W-1:0]       aid_audio,
   input  logic [ADDR_W-1:0]     aaddr_audio,
   input  logic                  avalid_audio,
   input  logic                  awrite_audio,
   input  logic [LEN_W-1:0]      alen_audio,
   input  logic [SIZE_W-1:0]     asize_audio,
   input  logic [BURST_W-1:0]    aburst_audio,
   output logic                  aready_audio,
   // demux address
   input  logic [ID_W-1:0]       aid_demux,
   input  logic [ADDR_W-1:0]     aaddr_demux,
   input  logic                  avalid_demux,
   input  logic                  awrite_demux,
   input  logic [LEN_W-1:0]      alen_demux,
   input  logic [SIZE_W-1:0]     asize_demux,
   input  logic [BURST_W-1:0]    aburst_demux,
   output logic                  aready_demux,
   // gdma address
   input  logic [ID_W-1:0]       aid_gdma,
   input  logic [ADDR_W-1:0]     aaddr_gdma,
   input  logic                  avalid_gdma,
   input  logic                  awrite_gdma,
   input  logic [LEN_W-1:0]      alen_gdma,
   input  logic [SIZE_W-1:0]     asize_gdma,
   input  logic [BURST_W-1:0]    aburst_gdma,
   output logic                  aready_gdma,
   // write data
   input  logic [ID_W-1:0]       wid_demux,
   input  logic [DATA_W-1:0]     wdata_demux,
   input  logic [DATA_W/8-1:0]   wstrb_demux,
   input  logic                  wlast_demux,
   input  logic                  wvalid_demux,
   output logic                  wready_demux,
   input  logic [ID_W-1:0]       wid_gdma,
   input  logic [DATA_W-1:0]     wdata_gdma,
   input  logic [DATA_W/8-1:0]   wstrb_gdma,
   input  logic                  wlast_gdma,
   input  logic                  wvalid_gdma,
   output logic                  wready_gdma,
   // read return
   output logic [ID_W-1:0]       rid_audio,
   output logic [DATA_W-1:0]     rdata_audio,
   output logic                  rlast_audio,
   output logic                  rvalid_audio,
   input  logic                  rready_audio,
   output logic [ID_W-1:0]       rid_gdma,
   output logic [DATA_W-1:0]     rdata_gdma,
   output logic                  rlast_gdma,
   output logic                  rvalid_gdma,
   input  logic                  rready_gdma,
   // DDR port
   output logic [ID_W+1:0]       aid_ddr,
   output logic [ADDR_W-1:0]     aaddr_ddr,
   output logic                  avalid_ddr,
   output logic                  awrite_ddr,
   output logic [LEN_W-1:0]      alen_ddr,
   output logic [SIZE_W-1:0]     asize_ddr,
   output logic [BURST_W-1:0]    aburst_ddr,
   input  logic                  aready_ddr,
   output logic [ID_W+1:0]       wid_ddr,
   output logic [DATA_W-1:0]     wdata_ddr,
   output logic [DATA_W/8-1:0]   wstrb_ddr,
   output logic                  wlast_ddr,
   output logic                  wvalid_ddr,
   input  logic                  wready_ddr,
   input  logic [ID_W+1:0]       rid_ddr,
   input  logic [DATA_W-1:0]     rdata_ddr,
   input  logic                  rlast_ddr,
   input  logic                  rvalid_ddr,
   output logic                  rready_ddr,
   output logic                  rsp_err
);

   astate_e              r_state;
   astate_e              w_state_nxt;
   logic [IDX_W-1:0]     r_rr;
   logic [N_MST-1:0]     w_elig;
   logic                 w_found;
   logic [IDX_W-1:0]     w_win;
   logic [IDX_W-1:0]     w_cand;
   logic                 w_grant;
   logic [ID_W-1:0]      w_sel_aid;
   logic [ADDR_W-1:0]    w_sel_aaddr;
   logic                 w_sel_awrite;
   logic [LEN_W-1:0]     w_sel_alen;
   logic [SIZE_W-1:0]    w_sel_asize;
   logic [BURST_W-1:0]   w_sel_aburst;
   logic [IDX_W-1:0]     w_q_head;
   logic                 w_q_full;
   logic                 w_q_empty;
   logic                 w_q_pop;
   logic [IDX_W-1:0]     w_rsel;

   //---------------------------------------------------------------- arbitration
   // Audio only reads and demux only writes; mismatched requests never win.
   assign w_elig[0] = avalid_audio & ~awrite_audio;
   assign w_elig[1] = avalid_demux &  awrite_demux & ~w_q_full;
   assign w_elig[2] = avalid_gdma  & (~awrite_gdma | ~w_q_full);

   // First eligible requester at or after the round-robin pointer
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_cand  = r_rr;
      for (int k = 0; k < N_MST; k++) begin
         if (!w_found && w_elig[w_cand]) begin
            w_found = 1'b1;
            w_win   = w_cand;
         end
         w_cand = rr_next(w_cand);
      end
   end

   always_comb begin
      case (w_win)
         M_DEMUX: begin
            w_sel_aid = aid_demux; w_sel_aaddr = aaddr_demux; w_sel_awrite = awrite_demux;
            w_sel_alen = alen_demux; w_sel_asize = asize_demux; w_sel_aburst = aburst_demux;
         end
         M_GDMA: begin
            w_sel_aid = aid_gdma; w_sel_aaddr = aaddr_gdma; w_sel_awrite = awrite_gdma;
            w_sel_alen = alen_gdma; w_sel_asize = asize_gdma; w_sel_aburst = aburst_gdma;
         end
         default: begin
            w_sel_aid = aid_audio; w_sel_aaddr = aaddr_audio; w_sel_awrite = awrite_audio;
            w_sel_alen = alen_audio; w_sel_asize = asize_audio; w_sel_aburst = aburst_audio;
         end
      endcase
   end

   //---------------------------------------------------------------- address FSM
   always_ff @(posedge gclk or negedge gresetn) begin
      if (!gresetn) r_state <= A_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         A_IDLE:  if (w_found)    w_state_nxt = A_BUSY;
         A_BUSY:  if (aready_ddr) w_state_nxt = A_IDLE;
         default:                 w_state_nxt = A_IDLE;
      endcase
   end

   always_comb begin
      w_grant      = (r_state == A_IDLE) & w_found;
      aready_audio = w_grant & (w_win == M_AUDIO);
      aready_demux = w_grant & (w_win == M_DEMUX);
      aready_gdma  = w_grant & (w_win == M_GDMA);
      avalid_ddr   = (r_state == A_BUSY);
   end

   // Fields are captured at grant and held through A_BUSY
   always_ff @(posedge gclk or negedge gresetn) begin
      if (!gresetn) begin
         aid_ddr    <= '0;
         aaddr_ddr  <= '0;
         awrite_ddr <= 1'b0;
         alen_ddr   <= '0;
         asize_ddr  <= '0;
         aburst_ddr <= '0;
         r_rr       <= '0;
      end else if (w_grant) begin
         aid_ddr    <= {w_win, w_sel_aid};
         aaddr_ddr  <= w_sel_aaddr;
         awrite_ddr <= w_sel_awrite;
         alen_ddr   <= w_sel_alen;
         asize_ddr  <= w_sel_asize;
         aburst_ddr <= w_sel_aburst;
         r_rr       <= rr_next(w_win);
      end
   end

   //---------------------------------------------------------------- write data
   ddr_axi_arb_wq #(.WQ_DEPTH(WQ_DEPTH)) u_wq (
      .i_clk      (gclk),
      .i_rst_n    (gresetn),
      .i_push     (w_grant & w_sel_awrite),
      .i_push_idx (w_win),
      .i_pop      (w_q_pop),
      .o_head     (w_q_head),
      .o_full     (w_q_full),
      .o_empty    (w_q_empty)
   );

   // Only demux or gdma can ever be queued; anything but gdma means demux
   always_comb begin
      wid_ddr      = '0;
      wdata_ddr    = '0;
      wstrb_ddr    = '0;
      wlast_ddr    = 1'b0;
      wvalid_ddr   = 1'b0;
      wready_demux = 1'b0;
      wready_gdma  = 1'b0;
      if (!w_q_empty) begin
         if (w_q_head == M_GDMA) begin
            wid_ddr     = {w_q_head, wid_gdma};
            wdata_ddr   = wdata_gdma;
            wstrb_ddr   = wstrb_gdma;
            wlast_ddr   = wlast_gdma;
            wvalid_ddr  = wvalid_gdma;
            wready_gdma = wready_ddr;
         end else begin
            wid_ddr      = {w_q_head, wid_demux};
            wdata_ddr    = wdata_demux;
            wstrb_ddr    = wstrb_demux;
            wlast_ddr    = wlast_demux;
            wvalid_ddr   = wvalid_demux;
            wready_demux = wready_ddr;
         end
      end
   end

   assign w_q_pop = wvalid_ddr & wready_ddr & wlast_ddr;

   //---------------------------------------------------------------- read data
   assign w_rsel       = rid_ddr[ID_W+1:ID_W];
   assign rid_audio    = rid_ddr[ID_W-1:0];
   assign rid_gdma     = rid_ddr[ID_W-1:0];
   assign rdata_audio  = rdata_ddr;
   assign rdata_gdma   = rdata_ddr;
   assign rlast_audio  = rlast_ddr;
   assign rlast_gdma   = rlast_ddr;
   assign rvalid_audio = rvalid_ddr & (w_rsel == M_AUDIO);
   assign rvalid_gdma  = rvalid_ddr & (w_rsel == M_GDMA);

   // Unroutable beats are accepted and discarded so the DDR port never stalls
   always_comb begin
      case (w_rsel)
         M_AUDIO: rready_ddr = rready_audio;
         M_GDMA:  rready_ddr = rready_gdma;
         default: rready_ddr = 1'b1;
      endcase
   end

   always_ff @(posedge gclk or negedge gresetn) begin
      if (!gresetn)                         rsp_err <= 1'b0;
      else if (rvalid_ddr && w_rsel[0])     rsp_err <= 1'b1;
   end

endmodule
`default_nettype wire

// File: tb/tb_ddr_axi_arb.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_ddr_axi_arb
// Purpose  : Self-checking bench for ddr_axi_arb: directed scenarios plus
//            randomized traffic compared against a behavioural model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_ddr_axi_arb;

   localparam int ID_W = 4, ADDR_W = 32, DATA_W = 64, WQ_DEPTH = 4, SW = DATA_W/8;

   logic gclk, gresetn;
   logic [ID_W-1:0] aid_audio, aid_demux, aid_gdma;
   logic [ADDR_W-1:0] aaddr_audio, aaddr_demux, aaddr_gdma;
   logic avalid_audio, avalid_demux, avalid_gdma;
   logic awrite_audio, awrite_demux, awrite_gdma;
   logic [3:0] alen_audio, alen_demux, alen_gdma;
   logic [2:0] asize_audio, asize_demux, asize_gdma;
   logic [1:0] aburst_audio, aburst_demux, aburst_gdma;
   logic aready_audio, aready_demux, aready_gdma;
   logic [ID_W-1:0] wid_demux, wid_gdma;
   logic [DATA_W-1:0] wdata_demux, wdata_gdma;
   logic [SW-1:0] wstrb_demux, wstrb_gdma;
   logic wlast_demux, wlast_gdma, wvalid_demux, wvalid_gdma, wready_demux, wready_gdma;
   logic [ID_W-1:0] rid_audio, rid_gdma;
   logic [DATA_W-1:0] rdata_audio, rdata_gdma;
   logic rlast_audio, rlast_gdma, rvalid_audio, rvalid_gdma, rready_audio, rready_gdma;
   logic [ID_W+1:0] aid_ddr, wid_ddr, rid_ddr;
   logic [ADDR_W-1:0] aaddr_ddr;
   logic avalid_ddr, awrite_ddr, aready_ddr;
   logic [3:0] alen_ddr;
   logic [2:0] asize_ddr;
   logic [1:0] aburst_ddr;
   logic [DATA_W-1:0] wdata_ddr, rdata_ddr;
   logic [SW-1:0] wstrb_ddr;
   logic wlast_ddr, wvalid_ddr, wready_ddr, rlast_ddr, rvalid_ddr, rready_ddr, rsp_err;

   int n_checks = 0;
   int n_fail   = 0;

   ddr_axi_arb #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WQ_DEPTH(WQ_DEPTH)) dut (
      .gclk(gclk), .gresetn(gresetn),
      .aid_audio(aid_audio), .aaddr_audio(aaddr_audio), .avalid_audio(avalid_audio),
      .awrite_audio(awrite_audio), .alen_audio(alen_audio), .asize_audio(asize_audio),
      .aburst_audio(aburst_audio), .aready_audio(aready_audio),
      .aid_demux(aid_demux), .aaddr_demux(aaddr_demux), .avalid_demux(avalid_demux),
      .awrite_demux(awrite_demux), .alen_demux(alen_demux), .asize_demux(asize_demux),
      .aburst_demux(aburst_demux), .aready_demux(aready_demux),
      .aid_gdma(aid_gdma), .aaddr_gdma(aaddr_gdma), .avalid_gdma(avalid_gdma),
      .awrite_gdma(awrite_gdma), .alen_gdma(alen_gdma), .asize_gdma(asize_gdma),
      .aburst_gdma(aburst_gdma), .aready_gdma(aready_gdma),
      .wid_demux(wid_demux), .wdata_demux(wdata_demux), .wstrb_demux(wstrb_demux),
      .wlast_demux(wlast_demux), .wvalid_demux(wvalid_demux), .wready_demux(wready_demux),
      .wid_gdma(wid_gdma), .wdata_gdma(wdata_gdma), .wstrb_gdma(wstrb_gdma),
      .wlast_gdma(wlast_gdma), .wvalid_gdma(wvalid_gdma), .wready_gdma(wready_gdma),
      .rid_audio(rid_audio), .rdata_audio(rdata_audio), .rlast_audio(rlast_audio),
      .rvalid_audio(rvalid_audio), .rready_audio(rready_audio),
      .rid_gdma(rid_gdma), .rdata_gdma(rdata_gdma), .rlast_gdma(rlast_gdma),
      .rvalid_gdma(rvalid_gdma), .rready_gdma(rready_gdma),
      .aid_ddr(aid_ddr), .aaddr_ddr(aaddr_ddr), .avalid_ddr(avalid_ddr), .awrite_ddr(awrite_ddr),
      .alen_ddr(alen_ddr), .asize_ddr(asize_ddr), .aburst_ddr(aburst_ddr), .aready_ddr(aready_ddr),
      .wid_ddr(wid_ddr), .wdata_ddr(wdata_ddr), .wstrb_ddr(wstrb_ddr), .wlast_ddr(wlast_ddr),
      .wvalid_ddr(wvalid_ddr), .wready_ddr(wready_ddr),
      .rid_ddr(rid_ddr), .rdata_ddr(rdata_ddr), .rlast_ddr(rlast_ddr), .rvalid_ddr(rvalid_ddr),
      .rready_ddr(rready_ddr), .rsp_err(rsp_err)
   );

   initial gclk = 1'b0;
   always #5 gclk = ~gclk;

   task automatic idle_inputs();
      aid_audio = '0; aaddr_audio = '0; avalid_audio = 0; awrite_audio = 0; alen_audio = '0; asize_audio = '0; aburst_audio = '0;
      aid_demux = '0; aaddr_demux = '0; avalid_demux = 0; awrite_demux = 0; alen_demux = '0; asize_demux = '0; aburst_demux = '0;
      aid_gdma  = '0; aaddr_gdma  = '0; avalid_gdma  = 0; awrite_gdma  = 0; alen_gdma  = '0; asize_gdma  = '0; aburst_gdma  = '0;
      wid_demux = '0; wdata_demux = '0; wstrb_demux = '0; wlast_demux = 0; wvalid_demux = 0;
      wid_gdma  = '0; wdata_gdma  = '0; wstrb_gdma  = '0; wlast_gdma  = 0; wvalid_gdma  = 0;
      rready_audio = 0; rready_gdma = 0; aready_ddr = 0; wready_ddr = 0;
      rid_ddr = '0; rdata_ddr = '0; rlast_ddr = 0; rvalid_ddr = 0;
   endtask

   // Advance one clock; inputs are then driven 1 time unit after the edge
   task automatic step();
      @(posedge gclk);
      #1;
   endtask

   task automatic do_reset();
      gresetn = 1'b0;
      idle_inputs();
      repeat (2) @(posedge gclk);
      #1;
      gresetn = 1'b1;
   endtask

   task automatic test_reset();
      gresetn = 1'b0;
      idle_inputs();
      repeat (3) @(posedge gclk);
      #2;
      n_checks++; if (avalid_ddr !== 1'b0) begin n_fail++; $display("FAIL reset_avalid: got %b want 0", avalid_ddr); end
      n_checks++; if (aid_ddr !== '0 || aaddr_ddr !== '0) begin n_fail++; $display("FAIL reset_afields: got aid %h aaddr %h want 0", aid_ddr, aaddr_ddr); end
      n_checks++; if (wvalid_ddr !== 1'b0) begin n_fail++; $display("FAIL reset_wvalid: got %b want 0", wvalid_ddr); end
      n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
      n_checks++; if ({aready_audio, aready_demux, aready_gdma} !== 3'b000) begin n_fail++; $display("FAIL reset_aready: got %b want 000", {aready_audio, aready_demux, aready_gdma}); end
      @(posedge gclk); #1;
      gresetn = 1'b1;
   endtask

   task automatic test_audio_read();
      logic [DATA_W-1:0] d;
      do_reset();
      avalid_audio = 1; awrite_audio = 0; aaddr_audio = 32'h1000; alen_audio = 4'd3; aid_audio = 4'd5;
      asize_audio = 3'd3; aburst_audio = 2'd1;
      #1;
      n_checks++; if (aready_audio !== 1'b1) begin n_fail++; $display("FAIL audio_aready: got %b want 1", aready_audio); end
      step();
      avalid_audio = 0;
      #1;
      n_checks++; if (avalid_ddr !== 1'b1 || aid_ddr !== 6'h05) begin n_fail++; $display("FAIL audio_addr_out: got avalid %b aid %h want 1 05", avalid_ddr, aid_ddr); end
      n_checks++; if (aaddr_ddr !== 32'h1000 || alen_ddr !== 4'd3 || awrite_ddr !== 1'b0) begin n_fail++; $display("FAIL audio_fields: got %h %h %b", aaddr_ddr, alen_ddr, awrite_ddr); end
      aready_ddr = 1;
      step();
      aready_ddr = 0;
      #1;
      n_checks++; if (avalid_ddr !== 1'b0) begin n_fail++; $display("FAIL audio_addr_done: got %b want 0", avalid_ddr); end
      for (int b = 0; b < 4; b++) begin
         d = {$urandom, $urandom};
         rvalid_ddr = 1; rid_ddr = 6'h05; rdata_ddr = d; rlast_ddr = (b == 3); rready_audio = 1;
         #1;
         n_checks++;
         if (rvalid_audio !== 1'b1 || rid_audio !== 4'd5 || rdata_audio !== d || rlast_audio !== (b == 3) || rvalid_gdma !== 1'b0 || rready_ddr !== 1'b1) begin
            n_fail++; $display("FAIL audio_rbeat%0d: got v%b id%h d%h l%b gv%b rr%b want v1 id5 d%h l%b", b, rvalid_audio, rid_audio, rdata_audio, rlast_audio, rvalid_gdma, rready_ddr, d, (b == 3));
         end
         step();
      end
      idle_inputs();
   endtask

   task automatic test_rr_order();
      int exp_w;
      do_reset();
      avalid_audio = 1; awrite_audio = 0;
      avalid_demux = 1; awrite_demux = 1; wvalid_demux = 1; wlast_demux = 1;
      avalid_gdma  = 1; awrite_gdma  = 0;
      aready_ddr = 1; wready_ddr = 1;
      for (int c = 0; c < 12; c++) begin
         exp_w = (c % 2 == 0) ? (c / 2) % 3 : -1;
         #1;
         n_checks++;
         if (aready_audio !== (exp_w == 0) || aready_demux !== (exp_w == 1) || aready_gdma !== (exp_w == 2)) begin
            n_fail++; $display("FAIL rr_order c%0d: got %b%b%b want winner %0d", c, aready_audio, aready_demux, aready_gdma, exp_w);
         end
         step();
      end
      idle_inputs();
   endtask

   task automatic test_write_order();
      logic [DATA_W-1:0] g, d0, d1;
      g = {$urandom, $urandom}; d0 = {$urandom, $urandom}; d1 = {$urandom, $urandom};
      do_reset();
      avalid_demux = 1; awrite_demux = 1; alen_demux = 4'd1; aid_demux = 4'd3;
      avalid_gdma  = 1; awrite_gdma  = 1; alen_gdma  = 4'd0; aid_gdma  = 4'd7;
      wvalid_gdma = 1; wlast_gdma = 1; wdata_gdma = g; wid_gdma = 4'd7;
      wready_ddr = 1; aready_ddr = 1;
      #1;
      n_checks++; if (aready_demux !== 1'b1 || aready_gdma !== 1'b0 || wready_gdma !== 1'b0) begin n_fail++; $display("FAIL wo_c0: got ad%b ag%b wg%b want 1 0 0", aready_demux, aready_gdma, wready_gdma); end
      step(); avalid_demux = 0; #1;
      n_checks++; if (wready_gdma !== 1'b0 || wvalid_ddr !== 1'b0) begin n_fail++; $display("FAIL wo_c1: got wg%b wv%b want 0 0", wready_gdma, wvalid_ddr); end
      step(); #1;
      n_checks++; if (aready_gdma !== 1'b1) begin n_fail++; $display("FAIL wo_gdma_grant: got %b want 1", aready_gdma); end
      step(); avalid_gdma = 0;
      wvalid_demux = 1; wlast_demux = 0; wdata_demux = d0; wid_demux = 4'd3; #1;
      n_checks++; if (wready_demux !== 1'b1 || wready_gdma !== 1'b0 || wid_ddr !== 6'h13 || wdata_ddr !== d0) begin n_fail++; $display("FAIL wo_demux_b0: got wd%b wg%b id%h d%h want 1 0 13 %h", wready_demux, wready_gdma, wid_ddr, wdata_ddr, d0); end
      step(); wlast_demux = 1; wdata_demux = d1; #1;
      n_checks++; if (wlast_ddr !== 1'b1 || wready_gdma !== 1'b0 || wdata_ddr !== d1) begin n_fail++; $display("FAIL wo_demux_b1: got l%b wg%b d%h want 1 0 %h", wlast_ddr, wready_gdma, wdata_ddr, d1); end
      step(); wvalid_demux = 0; #1;
      n_checks++; if (wready_gdma !== 1'b1 || wvalid_ddr !== 1'b1 || wid_ddr !== 6'h27 || wdata_ddr !== g || wready_demux !== 1'b0) begin n_fail++; $display("FAIL wo_gdma_data: got wg%b wv%b id%h d%h wd%b want 1 1 27 %h 0", wready_gdma, wvalid_ddr, wid_ddr, wdata_ddr, wready_demux, g); end
      step(); #1;
      n_checks++; if (wvalid_ddr !== 1'b0 || wready_gdma !== 1'b0) begin n_fail++; $display("FAIL wo_drained: got wv%b wg%b want 0 0", wvalid_ddr, wready_gdma); end
      idle_inputs();
   endtask

   task automatic test_queue_full();
      do_reset();
      aready_ddr = 1; avalid_gdma = 1; awrite_gdma = 1;
      for (int i = 0; i < 8; i++) begin
         #1;
         n_checks++; if (aready_gdma !== (i % 2 == 0)) begin n_fail++; $display("FAIL qf_fill%0d: got %b want %b", i, aready_gdma, (i % 2 == 0)); end
         step();
      end
      avalid_audio = 1; awrite_audio = 0; #1;
      n_checks++; if (aready_gdma !== 1'b0 || aready_audio !== 1'b1) begin n_fail++; $display("FAIL qf_blocked: got ag%b aa%b want 0 1", aready_gdma, aready_audio); end
      step(); avalid_audio = 0; step();
      wvalid_gdma = 1; wlast_gdma = 1; wready_ddr = 1; #1;
      n_checks++; if (aready_gdma !== 1'b0 || wready_gdma !== 1'b1) begin n_fail++; $display("FAIL qf_pop_cycle: got ag%b wg%b want 0 1", aready_gdma, wready_gdma); end
      step(); wvalid_gdma = 0; #1;
      n_checks++; if (aready_gdma !== 1'b1) begin n_fail++; $display("FAIL qf_after_pop: got %b want 1", aready_gdma); end
      step();
      idle_inputs();
   endtask

   task automatic test_bad_id();
      do_reset();
      rvalid_ddr = 1; rid_ddr = 6'h13; #1;
      n_checks++; if (rready_ddr !== 1'b1 || rvalid_audio !== 1'b0 || rvalid_gdma !== 1'b0 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL bad_id_beat: got rr%b va%b vg%b err%b want 1 0 0 0", rready_ddr, rvalid_audio, rvalid_gdma, rsp_err); end
      step(); rvalid_ddr = 0; rid_ddr = '0; #1;
      n_checks++; if (rsp_err !== 1'b1) begin n_fail++; $display("FAIL bad_id_err_set: got %b want 1", rsp_err); end
      repeat (3) step();
      n_checks++; if (rsp_err !== 1'b1) begin n_fail++; $display("FAIL bad_id_err_sticky: got %b want 1", rsp_err); end
      gresetn = 0; #1;
      n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL bad_id_err_clear: got %b want 0", rsp_err); end
      step(); gresetn = 1;
   endtask

   task automatic test_reset_midburst();
      do_reset();
      avalid_demux = 1; awrite_demux = 1; aid_demux = 4'd9;
      step(); avalid_demux = 0; #1;
      n_checks++; if (avalid_ddr !== 1'b1) begin n_fail++; $display("FAIL rm_busy: got %b want 1", avalid_ddr); end
      gresetn = 0; wvalid_demux = 1; #1;
      n_checks++; if (avalid_ddr !== 1'b0 || wvalid_ddr !== 1'b0 || wready_demux !== 1'b0) begin n_fail++; $display("FAIL rm_async: got av%b wv%b wd%b want 0 0 0", avalid_ddr, wvalid_ddr, wready_demux); end
      step(); gresetn = 1; wvalid_demux = 0;
      avalid_audio = 1; avalid_gdma = 1; #1;
      n_checks++; if (aready_audio !== 1'b1 || aready_gdma !== 1'b0) begin n_fail++; $display("FAIL rm_first_grant: got aa%b ag%b want 1 0", aready_audio, aready_gdma); end
      step();
      idle_inputs();
   endtask

   task automatic test_read_routing();
      int sel; bit exp_err; bit ev_a, ev_g, e_rr;
      logic [1:0] s2;
      do_reset();
      exp_err = 0;
      for (int c = 0; c < 80; c++) begin
         sel = $urandom_range(0, 3); s2 = sel[1:0];
         rid_ddr = {s2, 4'($urandom)}; rdata_ddr = {$urandom, $urandom}; rlast_ddr = 1'($urandom);
         rvalid_ddr = 1'($urandom); rready_audio = 1'($urandom); rready_gdma = 1'($urandom);
         #1;
         ev_a = rvalid_ddr && sel == 0;
         ev_g = rvalid_ddr && sel == 2;
         e_rr = (sel == 0) ? rready_audio : (sel == 2) ? rready_gdma : 1'b1;
         n_checks++;
         if (rvalid_audio !== ev_a || rvalid_gdma !== ev_g || rready_ddr !== e_rr || rsp_err !== exp_err) begin
            n_fail++; $display("FAIL rd_route c%0d: got va%b vg%b rr%b err%b want %b %b %b %b", c, rvalid_audio, rvalid_gdma, rready_ddr, rsp_err, ev_a, ev_g, e_rr, exp_err);
         end
         n_checks++;
         if (rid_audio !== rid_ddr[3:0] || rid_gdma !== rid_ddr[3:0] || rdata_audio !== rdata_ddr || rdata_gdma !== rdata_ddr || rlast_gdma !== rlast_ddr) begin
            n_fail++; $display("FAIL rd_payload c%0d: got id%h/%h d%h want id%h d%h", c, rid_audio, rid_gdma, rdata_audio, rid_ddr[3:0], rdata_ddr);
         end
         if (rvalid_ddr && (sel % 2 == 1)) exp_err = 1;
         step();
      end
      idle_inputs();
   endtask

   task automatic test_random_traffic();
      int rr, win, h, m;
      bit busy, full, elig, pop, exp_wv;
      int q[$];
      bit pend[3]; bit wr[3];
      logic [ID_W-1:0] fid[3]; logic [ADDR_W-1:0] fad[3]; logic [3:0] fln[3]; logic [2:0] fsz[3]; logic [1:0] fbu[3];
      logic [5:0] e_aid; logic [31:0] e_ad; logic [3:0] e_ln; logic [2:0] e_sz; logic [1:0] e_bu; bit e_wr;
      logic [5:0] e_wid; logic [63:0] e_wd; logic e_wl; logic [1:0] h2;
      do_reset();
      rr = 0; busy = 0; q.delete();
      e_aid = '0; e_ad = '0; e_ln = '0; e_sz = '0; e_bu = '0; e_wr = 0;
      for (int i = 0; i < 3; i++) begin pend[i] = 0; wr[i] = 0; fid[i] = '0; fad[i] = '0; fln[i] = '0; fsz[i] = '0; fbu[i] = '0; end
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 3; i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i] = 1; fid[i] = 4'($urandom); fad[i] = $urandom; fln[i] = 4'($urandom);
               fsz[i] = 3'($urandom); fbu[i] = 2'($urandom);
               wr[i] = (i == 0) ? 1'b0 : (i == 1) ? 1'b1 : 1'($urandom);
            end
         end
         avalid_audio = pend[0]; aid_audio = fid[0]; aaddr_audio = fad[0]; awrite_audio = wr[0]; alen_audio = fln[0]; asize_audio = fsz[0]; aburst_audio = fbu[0];
         avalid_demux = pend[1]; aid_demux = fid[1]; aaddr_demux = fad[1]; awrite_demux = wr[1]; alen_demux = fln[1]; asize_demux = fsz[1]; aburst_demux = fbu[1];
         avalid_gdma  = pend[2]; aid_gdma  = fid[2]; aaddr_gdma  = fad[2]; awrite_gdma  = wr[2]; alen_gdma  = fln[2]; asize_gdma  = fsz[2]; aburst_gdma  = fbu[2];
         wvalid_demux = 1'($urandom); wlast_demux = 1'($urandom); wdata_demux = {$urandom, $urandom}; wid_demux = 4'($urandom); wstrb_demux = 8'($urandom);
         wvalid_gdma  = 1'($urandom); wlast_gdma  = 1'($urandom); wdata_gdma  = {$urandom, $urandom}; wid_gdma  = 4'($urandom); wstrb_gdma  = 8'($urandom);
         wready_ddr = 1'($urandom); aready_ddr = 1'($urandom);
         #1;
         full = (q.size() == WQ_DEPTH);
         win = -1;
         if (!busy) begin
            for (int k = 0; k < 3; k++) begin
               m = (rr + k) % 3;
               elig = pend[m] && (wr[m] ? (m != 0 && !full) : (m != 1));
               if (elig && win < 0) win = m;
            end
         end
         n_checks++;
         if (aready_audio !== (win == 0) || aready_demux !== (win == 1) || aready_gdma !== (win == 2)) begin
            n_fail++; $display("FAIL rnd_grant c%0d: got %b%b%b want winner %0d", c, aready_audio, aready_demux, aready_gdma, win);
         end
         n_checks++;
         if (avalid_ddr !== busy || (busy && (aid_ddr !== e_aid || aaddr_ddr !== e_ad || alen_ddr !== e_ln || asize_ddr !== e_sz || aburst_ddr !== e_bu || awrite_ddr !== e_wr))) begin
            n_fail++; $display("FAIL rnd_addr c%0d: got v%b id%h a%h want v%b id%h a%h", c, avalid_ddr, aid_ddr, aaddr_ddr, busy, e_aid, e_ad);
         end
         h = (q.size() > 0) ? q[0] : -1;
         h2 = h[1:0];
         exp_wv = (h == 1) ? wvalid_demux : (h == 2) ? wvalid_gdma : 1'b0;
         e_wid = (h == 1) ? {h2, wid_demux} : {h2, wid_gdma};
         e_wd  = (h == 1) ? wdata_demux : wdata_gdma;
         e_wl  = (h == 1) ? wlast_demux : wlast_gdma;
         n_checks++;
         if (wvalid_ddr !== exp_wv || wready_demux !== (h == 1 && wready_ddr) || wready_gdma !== (h == 2 && wready_ddr)) begin
            n_fail++; $display("FAIL rnd_wctl c%0d: got wv%b wd%b wg%b want head %0d wv%b", c, wvalid_ddr, wready_demux, wready_gdma, h, exp_wv);
         end
         if (h > 0) begin
            n_checks++;
            if (wid_ddr !== e_wid || wdata_ddr !== e_wd || wlast_ddr !== e_wl) begin
               n_fail++; $display("FAIL rnd_wdata c%0d: got id%h d%h l%b want id%h d%h l%b", c, wid_ddr, wdata_ddr, wlast_ddr, e_wid, e_wd, e_wl);
            end
         end
         pop = exp_wv && wready_ddr && e_wl;
         if (busy && aready_ddr) busy = 0;
         if (win >= 0) begin
            e_aid = {2'(win), fid[win]}; e_ad = fad[win]; e_ln = fln[win]; e_sz = fsz[win]; e_bu = fbu[win]; e_wr = wr[win];
            busy = 1; rr = (win + 1) % 3; pend[win] = 0;
         end
         if (pop) void'(q.pop_front());
         if (win >= 0 && e_wr) q.push_back(win);
         step();
      end
      idle_inputs();
   endtask

   initial begin
      gresetn = 1'b0;
      idle_inputs();
      test_reset();
      test_audio_read();
      test_rr_order();
      test_write_order();
      test_queue_full();
      test_bad_id();
      test_reset_midburst();
      test_read_routing();
      test_random_traffic();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ddr_axi_arb.md
Name: ddr_axi_arb

Overview:
- Three-way arbiter that shares the single DDR AXI master port between three requesters: audio-out (read only), demux (write only) and gdma (read/write).
- Shared address channel (aid/aaddr/avalid/awrite) uses round-robin arbitration.
- Write data is ordered by a grant-order queue; read data is routed back by tagged ID bits.
- Sits between the requester AXI slave ports and the DDR controller port inside the bus subsystem.

Parameters:
- ID_W, 4, upstream ID width; DDR-side ID width is ID_W+2.
- ADDR_W, 32, address width.
- DATA_W, 64, data width; strobe width is DATA_W/8.
- WQ_DEPTH, 4, write grant-order queue depth (power of 2, ≥2).

Ports:
- gclk  in  1  clock.
- gresetn  in  1  asynchronous active-low reset.
- aid_<m>, aaddr_<m>, avalid_<m>, awrite_<m>, alen_<m>, asize_<m>, aburst_<m>  in  ID_W/ADDR_W/1/1/4/3/2  address request; m ∈ {audio, demux, gdma}.
- aready_<m>  out  1  address accept, one per requester.
- wid_<m>, wdata_<m>, wstrb_<m>, wlast_<m>, wvalid_<m>  in  ID_W/DATA_W/DATA_W/8/1/1  write data; m ∈ {demux, gdma}.
- wready_<m>  out  1  write data accept; m ∈ {demux, gdma}.
- rid_<m>, rdata_<m>, rlast_<m>, rvalid_<m>  out  ID_W/DATA_W/1/1  read return; m ∈ {audio, gdma}.
- rready_<m>  in  1  read accept; m ∈ {audio, gdma}.
- aid_ddr, aaddr_ddr, avalid_ddr, awrite_ddr, alen_ddr, asize_ddr, aburst_ddr  out  ID_W+2/ADDR_W/1/1/4/3/2  DDR address channel.
- aready_ddr  in  1  DDR address accept.
- wid_ddr, wdata_ddr, wstrb_ddr, wlast_ddr, wvalid_ddr  out  ID_W+2/DATA_W/DATA_W/8/1/1  DDR write data.
- wready_ddr  in  1  DDR write accept.
- rid_ddr, rdata_ddr, rlast_ddr, rvalid_ddr  in  ID_W+2/DATA_W/1/1  DDR read data.
- rready_ddr  out  1  DDR read accept.
- rsp_err  out  1  sticky flag: read beat received with an unroutable ID.

Behaviour:
- Reset:
  - All outputs and registers go to 0.
  - Address FSM enters A_IDLE; write queue is emptied; round-robin pointer points at audio; rsp_err clears.
  - Reset asserted mid-burst abandons all transactions; no recovery is attempted.
- Master index encoding: audio=0, demux=1, gdma=2. aid_ddr = {idx[1:0], aid_<m>}; wid_ddr = {idx, wid_<m>}.
- Address FSM, A_IDLE:
  - Eligible requesters are those with avalid_<m>=1.
  - A write request (awrite=1) is ineligible while the write queue is full.
  - An audio request with awrite=1 or a demux request with awrite=0 is never granted and waits forever; it is a protocol violation and is not checked.
  - Winner is the first eligible requester at or after the RR pointer (order audio→demux→gdma→audio).
  - On a grant, in the same cycle: pulse aready_<winner> for 1 cycle; register all address fields into the DDR output registers; advance RR pointer to winner+1; if awrite, push winner onto the write queue; go to A_BUSY.
- Address FSM, A_BUSY:
  - avalid_ddr=1 and fields are held stable.
  - On aready_ddr=1, go to A_IDLE.
- Timing and throughput:
  - Latency is 1 cycle from request grant to avalid_ddr.
  - Minimum gap is 1 idle cycle between DDR address beats, so peak rate is one address every 2 cycles.
- Write data channel:
  - Queue head selects the source master (demux or gdma); the channel is a combinational pass-through.
  - wvalid_ddr = wvalid_<head> & !empty; wready_<head> = wready_ddr & !empty; the non-head wready is 0.
  - Pop the queue on wvalid_ddr & wready_ddr & wlast_ddr.
  - Data may precede its DDR address acceptance because the queue push happens at grant.
  - A push and a pop in the same cycle are both performed; occupancy is unchanged, including when the queue is full.
- Read data channel:
  - Combinational routing on rid_ddr[ID_W+1:ID_W]: 0 → audio, 2 → gdma.
  - rid_<m> = rid_ddr[ID_W-1:0]; rvalid_<m> = rvalid_ddr & sel; rready_ddr = rready_<sel>.
  - rdata/rlast are broadcast to both read requesters.
  - Index 1 or 3: rready_ddr=1 (beat is dropped), no rvalid is driven, and rsp_err is set until reset.
- Requester ordering: a requester's own reads/writes keep AXI ordering per ID; there is no reordering between requesters.

Decomposition:
- Package ddr_axi_arb_pkg holds:
  - Master index enum (M_AUDIO, M_DEMUX, M_GDMA).
  - IDX_W=2.
  - FSM state enum (A_IDLE, A_BUSY).
  - Field width constants (LEN_W=4, SIZE_W=3, BURST_W=2).
- Sub-module ddr_axi_arb_wq: a synchronous FIFO of 2-bit master indices with push, pop, head, full and empty, parameterised by WQ_DEPTH.

Test Plan:
- Audio read request (aaddr=0x1000, alen=3, aid=5), aready_ddr=1 on the second cycle → aready_audio pulses in cycle 0; aid_ddr=0x05 and avalid_ddr are high in cycle 1; a 4-beat return with rid_ddr=0x05 appears on rvalid_audio with rid_audio=5.
- All three requesters assert avalid continuously with aready_ddr=1 → grant order is audio, demux, gdma, audio…, one grant every 2 cycles.
- Demux write (alen=1) then gdma write (alen=0) are granted; gdma asserts wvalid first → wready_gdma stays 0 until demux's second beat with wlast is accepted, then gdma data passes.
- Four gdma writes with wvalid held low, then a fifth write request → the fifth is not granted (queue full) while an audio read is still granted; the fifth is granted after the first wlast handshake.
- Read beat with rid_ddr[ID_W+1:ID_W]=1 → rready_ddr=1, no rvalid on audio or gdma, rsp_err=1 and held until gresetn is asserted.
- gresetn asserted low while in A_BUSY with the queue non-empty → avalid_ddr=0 immediately, queue is empty, and the first grant after release goes to audio if it is requesting.
